// File: rtl/mmu_arbiter_pkg.sv
// rtl/mmu_arbiter_pkg.sv - shared types and exception codes for the IF/MEM MMU arbiter
package mmu_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_XLATE = 3'd1,
    ST_BUS   = 3'd2,
    ST_DONE  = 3'd3,
    ST_EXC   = 3'd4
  } state_t;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_IBE  = 5'd6;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  // Only a data store reports TLBS; fetches and loads both report TLBL.
  function automatic logic [4:0] tlb_exc_code(input src_t src, input logic we);
    return (src == SRC_MEM && we) ? EXC_TLBS : EXC_TLBL;
  endfunction

endpackage

// File: rtl/mmu_timeout_cnt.sv
// rtl/mmu_timeout_cnt.sv - bus acknowledge watchdog counter
module mmu_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt_q;
  logic [8:0] cnt_inc;

  // Expiry fires in the cycle whose increment would reach the limit, so bus_req
  // stays high for exactly TIMEOUT_CYCLES cycles.
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign expired = enable && (cnt_inc == 9'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/mmu_arbiter.sv
// rtl/mmu_arbiter.sv - arbitrates IF/MEM over one TLB lookup port and one memory bus
module mmu_arbiter
  import mmu_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [ADDR_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [ADDR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] tlb_addr_o,
  input  logic              tlb_hit_i,
  input  logic [ADDR_W-1:0] tlb_paddr_i,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [ADDR_W-1:0] bus_rdata,
  output logic              stallreq,
  output logic              exc_valid,
  output logic [4:0]        exc_code,
  output logic [ADDR_W-1:0] exc_badvaddr
);

  state_t            state_q, state_d;
  src_t              src_q, last_grant_q, grant_src;
  logic              grant_valid;
  logic [ADDR_W-1:0] vaddr_q, paddr_q, wdata_q, rdata_q;
  logic              we_q, discard_q, discard_eff;
  logic [3:0]        sel_q;
  logic [4:0]        exc_code_q;
  logic              cnt_clear, cnt_en, expired;

  mmu_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

  // A flush arriving in the same cycle as the bus completion already discards it.
  assign discard_eff = discard_q | flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_src   = SRC_IF;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush && (if_req || mem_req)) begin
          grant_valid = 1'b1;
          if (if_req && mem_req) grant_src = (last_grant_q == SRC_IF) ? SRC_MEM : SRC_IF;
          else                   grant_src = if_req ? SRC_IF : SRC_MEM;
          state_d = ST_XLATE;
        end
      end
      ST_XLATE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (tlb_hit_i) begin
          cnt_clear = 1'b1;
          state_d   = ST_BUS;
        end else begin
          state_d = ST_EXC;
        end
      end
      ST_BUS: begin
        cnt_en = !bus_ack;
        if (bus_ack)      state_d = discard_eff ? ST_IDLE : ST_DONE;
        else if (expired) state_d = discard_eff ? ST_IDLE : ST_EXC;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_EXC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q        <= SRC_IF;
      last_grant_q <= SRC_IF;
      vaddr_q      <= '0;
      paddr_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      we_q         <= 1'b0;
      sel_q        <= 4'h0;
      discard_q    <= 1'b0;
      exc_code_q   <= 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            src_q        <= grant_src;
            last_grant_q <= grant_src;
            discard_q    <= 1'b0;
            if (grant_src == SRC_IF) begin
              vaddr_q <= if_addr;
              we_q    <= 1'b0;
              sel_q   <= 4'hF;
              wdata_q <= '0;
            end else begin
              vaddr_q <= mem_addr;
              we_q    <= mem_we;
              sel_q   <= mem_sel;
              wdata_q <= mem_wdata;
            end
          end
        end
        ST_XLATE: begin
          if (tlb_hit_i) paddr_q    <= tlb_paddr_i;
          else           exc_code_q <= tlb_exc_code(src_q, we_q);
        end
        ST_BUS: begin
          if (flush) discard_q <= 1'b1;
          if (bus_ack) begin
            if (!discard_eff) rdata_q <= bus_rdata;
          end else if (expired) begin
            exc_code_q <= (src_q == SRC_IF) ? EXC_IBE : EXC_DBE;
          end
        end
        default: ;
      endcase
    end
  end

  assign tlb_addr_o   = (state_q == ST_XLATE) ? vaddr_q : '0;
  assign bus_req      = (state_q == ST_BUS);
  assign bus_we       = bus_req & we_q;
  assign bus_addr     = bus_req ? paddr_q : '0;
  assign bus_sel      = bus_req ? sel_q : 4'h0;
  assign bus_wdata    = bus_req ? wdata_q : '0;
  assign if_ack       = (state_q == ST_DONE) && (src_q == SRC_IF);
  assign mem_ack      = (state_q == ST_DONE) && (src_q == SRC_MEM);
  assign if_rdata     = rdata_q;
  assign mem_rdata    = rdata_q;
  assign exc_valid    = (state_q == ST_EXC);
  assign exc_code     = exc_valid ? exc_code_q : 5'd0;
  assign exc_badvaddr = exc_valid ? vaddr_q : '0;
  assign stallreq     = ~rst & ((if_req & ~if_ack) | (mem_req & ~mem_ack));

endmodule

// File: tb/tb_mmu_arbiter.sv
// tb/tb_mmu_arbiter.sv - scoreboard bench for mmu_arbiter
module tb_mmu_arbiter;

  localparam logic [31:0] RD_KEY = 32'h24021005;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [4:0]  code;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_sel = 4'h0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] tlb_addr_o;
  logic        tlb_hit_i;
  logic [31:0] tlb_paddr_i;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stallreq;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;

  logic        tlb_hit_en = 1'b1;
  exp_t        sb[$];
  bus_t        bq[$];
  logic [31:0] mem_next[$];
  int checks = 0, errors = 0, cycle = 0;
  int ack_delay = 1, bus_cnt = 0, bus_req_cycles = 0, events_seen = 0;

  always #5 clk = ~clk;

  assign tlb_hit_i   = tlb_hit_en;
  assign tlb_paddr_i = tlb_addr_o & 32'h1FFF_FFFF;

  mmu_arbiter #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .tlb_addr_o(tlb_addr_o), .tlb_hit_i(tlb_hit_i), .tlb_paddr_i(tlb_paddr_i),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stallreq(stallreq), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_badvaddr(exc_badvaddr)
  );

  // One cycle: bus responder, scoreboard pop on DUT events, requester drop on completion.
  task automatic tick();
    exp_t e;
    bus_t b;
    int kind_got;
    logic [31:0] data_got;
    @(negedge clk);
    cycle++;
    if (bus_req) begin
      bus_cnt++;
      bus_req_cycles++;
      if (bus_cnt == 1) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL bus_start unexpected: addr=%h", bus_addr);
        end else begin
          b = bq.pop_front();
          if ({bus_addr, bus_we, bus_sel, bus_wdata} !== {b.addr, b.we, b.sel, b.wdata}) begin
            errors++;
            $display("FAIL bus_fields: got addr=%h we=%b sel=%h wdata=%h, expected addr=%h we=%b sel=%h wdata=%h",
                     bus_addr, bus_we, bus_sel, bus_wdata, b.addr, b.we, b.sel, b.wdata);
          end
        end
      end
      bus_ack   = (ack_delay >= 0) && (bus_cnt == ack_delay + 1);
      bus_rdata = bus_ack ? (bus_addr ^ RD_KEY) : 32'h0;
    end else begin
      bus_cnt   = 0;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
    end
    if (if_ack || mem_ack || exc_valid) begin
      events_seen++;
      checks++;
      kind_got = exc_valid ? 2 : (mem_ack ? 1 : 0);
      data_got = exc_valid ? exc_badvaddr : (mem_ack ? mem_rdata : if_rdata);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL event unexpected: kind=%0d data=%h cycle=%0d", kind_got, data_got, cycle);
      end else begin
        e = sb.pop_front();
        if (kind_got !== e.kind || data_got !== e.data || (e.kind == 2 && exc_code !== e.code) ||
            (e.cyc >= 0 && cycle !== e.cyc)) begin
          errors++;
          $display("FAIL event: got kind=%0d data=%h code=%0d cycle=%0d, expected kind=%0d data=%h code=%0d cycle=%0d",
                   kind_got, data_got, exc_code, cycle, e.kind, e.data, e.code, e.cyc);
        end
      end
    end
    if (if_ack) if_req = 1'b0;
    if (mem_ack) begin
      if (mem_next.size() != 0) mem_addr = mem_next.pop_front();
      else mem_req = 1'b0;
    end
    if (exc_valid) begin
      if_req  = 1'b0;
      mem_req = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bq.size() != 0 || bus_req) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s drain timeout: sb=%0d bq=%0d bus_req=%b", name, sb.size(), bq.size(), bus_req);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({bus_req, if_ack, mem_ack, exc_valid, stallreq} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {bus_req, if_ack, mem_ack, exc_valid, stallreq});
    end
    checks++;
    if ({tlb_addr_o, bus_addr, if_rdata, exc_badvaddr} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: tlb=%h bus=%h rdata=%h bad=%h expected 0", tlb_addr_o, bus_addr, if_rdata, exc_badvaddr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_hit();
    int c;
    ack_delay = 1;
    tlb_hit_en = 1'b1;
    if_addr = 32'h8000_1000;
    if_req = 1'b1;
    c = cycle;
    sb.push_back('{0, 32'h2402_0005, 5'd0, c + 4});
    bq.push_back('{32'h0000_1000, 1'b0, 4'hF, 32'h0});
    tick();
    checks++;
    if (tlb_addr_o !== 32'h8000_1000 || stallreq !== 1'b1) begin
      errors++;
      $display("FAIL fetch_xlate: tlb_addr=%h stall=%b expected 80001000/1", tlb_addr_o, stallreq);
    end
    drain("fetch_hit");
    checks++;
    if (stallreq !== 1'b0 || tlb_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL fetch_idle: stall=%b tlb_addr=%h expected 0/0", stallreq, tlb_addr_o);
    end
  endtask

  task automatic test_contention();
    int c;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ack_delay = 0;
    if_addr   = 32'h8000_2000;
    mem_addr  = 32'h8000_3000;
    mem_we    = 1'b0;
    mem_sel   = 4'h3;
    mem_wdata = 32'h0000_BEEF;
    mem_next.push_back(32'h8000_4000);
    if_req  = 1'b1;
    mem_req = 1'b1;
    c = cycle;
    sb.push_back('{1, 32'h0000_3000 ^ RD_KEY, 5'd0, c + 3});
    sb.push_back('{0, 32'h0000_2000 ^ RD_KEY, 5'd0, -1});
    sb.push_back('{1, 32'h0000_4000 ^ RD_KEY, 5'd0, -1});
    bq.push_back('{32'h0000_3000, 1'b0, 4'h3, 32'h0000_BEEF});
    bq.push_back('{32'h0000_2000, 1'b0, 4'hF, 32'h0});
    bq.push_back('{32'h0000_4000, 1'b0, 4'h3, 32'h0000_BEEF});
    drain("contention");
  endtask

  task automatic test_tlb_miss();
    logic [31:0] addrs[3] = '{32'h0040_3000, 32'h0040_5000, 32'h8000_7000};
    logic [4:0]  codes[3] = '{5'd3, 5'd2, 5'd2};
    int c;
    tlb_hit_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_req_cycles = 0;
      events_seen = 0;
      if (i == 2) begin
        if_addr = addrs[i];
        if_req  = 1'b1;
      end else begin
        mem_addr  = addrs[i];
        mem_we    = (i == 0);
        mem_sel   = 4'hF;
        mem_wdata = 32'h1234_5678;
        mem_req   = 1'b1;
      end
      c = cycle;
      sb.push_back('{2, addrs[i], codes[i], c + 2});
      drain("tlb_miss");
      checks++;
      if (bus_req_cycles !== 0 || events_seen !== 1) begin
        errors++;
        $display("FAIL tlb_miss_%0d: bus cycles=%0d events=%0d expected 0/1", i, bus_req_cycles, events_seen);
      end
    end
    tlb_hit_en = 1'b1;
  endtask

  task automatic test_timeout();
    int c;
    ack_delay = -1;
    for (int i = 0; i < 2; i++) begin
      bus_req_cycles = 0;
      c = cycle;
      if (i == 0) begin
        if_addr = 32'h8000_5000;
        if_req  = 1'b1;
        bq.push_back('{32'h0000_5000, 1'b0, 4'hF, 32'h0});
        sb.push_back('{2, 32'h8000_5000, 5'd6, c + 10});
      end else begin
        mem_addr  = 32'h0040_6000;
        mem_we    = 1'b1;
        mem_sel   = 4'hC;
        mem_wdata = 32'hCAFE_0001;
        mem_req   = 1'b1;
        bq.push_back('{32'h0040_6000, 1'b1, 4'hC, 32'hCAFE_0001});
        sb.push_back('{2, 32'h0040_6000, 5'd7, c + 10});
      end
      drain("timeout");
      checks++;
      if (bus_req_cycles !== 8) begin
        errors++;
        $display("FAIL timeout_len_%0d: bus_req cycles=%0d expected 8", i, bus_req_cycles);
      end
    end
    // Ack arriving in the final allowed cycle must win over the timeout.
    ack_delay = 7;
    bus_req_cycles = 0;
    if_addr = 32'h8000_8000;
    if_req  = 1'b1;
    c = cycle;
    bq.push_back('{32'h0000_8000, 1'b0, 4'hF, 32'h0});
    sb.push_back('{0, 32'h0000_8000 ^ RD_KEY, 5'd0, c + 10});
    drain("ack_vs_timeout");
    checks++;
    if (bus_req_cycles !== 8) begin
      errors++;
      $display("FAIL ack_vs_timeout_len: bus_req cycles=%0d expected 8", bus_req_cycles);
    end
  endtask

  task automatic test_flush_bus();
    ack_delay = 4;
    bus_req_cycles = 0;
    events_seen = 0;
    if_addr = 32'h8000_9000;
    if_req  = 1'b1;
    bq.push_back('{32'h0000_9000, 1'b0, 4'hF, 32'h0});
    repeat (3) tick();
    flush  = 1'b1;
    if_req = 1'b0;
    tick();
    flush = 1'b0;
    drain("flush_bus");
    checks++;
    if (bus_req_cycles !== 5 || events_seen !== 0 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL flush_bus: bus cycles=%0d events=%0d stall=%b expected 5/0/0", bus_req_cycles, events_seen, stallreq);
    end
  endtask

  task automatic test_reset_mid_bus();
    ack_delay = -1;
    if_addr = 32'h8000_A000;
    if_req  = 1'b1;
    bq.push_back('{32'h0000_A000, 1'b0, 4'hF, 32'h0});
    repeat (3) tick();
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: bus_req=%b expected 1", bus_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus_req, stallreq, if_ack, mem_ack, exc_valid, bus_we, bus_sel, exc_code} !== 14'h0 ||
        {tlb_addr_o, bus_addr, bus_wdata, exc_badvaddr} !== 128'h0) begin
      errors++;
      $display("FAIL rst_mid_bus: bus_req=%b stall=%b bus_addr=%h exc=%b expected all 0", bus_req, stallreq, bus_addr, exc_valid);
    end
    if_req = 1'b0;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    checks++;
    if (bus_req !== 1'b0 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: bus_req=%b stall=%b expected 0/0", bus_req, stallreq);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_hit();
    test_contention();
    test_tlb_miss();
    test_timeout();
    test_flush_bus();
    test_reset_mid_bus();
    test_fetch_hit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
